// File: rtl/pll_sup_pkg.sv
// Shared types and helpers for the PLL supervisor.
package pll_sup_pkg;

    typedef enum logic [2:0] {
        StRstPll,
        StWaitLock,
        StStable,
        StMeasure,
        StRun,
        StFail,
        StFault
    } state_e;

    // True when count lies within expected +/- tol, inclusive; written to avoid underflow.
    function automatic logic count_in_range(input int unsigned count,
                                            input int unsigned expected,
                                            input int unsigned tol);
        return ((count + tol) >= expected) && (count <= (expected + tol));
    endfunction

endpackage

// File: rtl/pll_sup_sync.sv
// Three-flop synchronizer: second flop is the synchronized level, 2nd XOR 3rd flags a transition.
module pll_sup_sync (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o,
    output logic edge_o
);

    logic [2:0] sync_q;

    // Shift the asynchronous input through the flop chain
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[1:0], d_i};
        end
    end

    assign q_o    = sync_q[1];
    assign edge_o = sync_q[1] ^ sync_q[2];

endmodule

// File: rtl/pll_supervisor.sv
// PLL bring-up sequencer, frequency checker and audio-domain reset generator.
module pll_supervisor
    import pll_sup_pkg::*;
#(
    parameter int unsigned RST_PULSE_CYCLES   = 16,
    parameter int unsigned LOCK_TIMEOUT       = 50000,
    parameter int unsigned LOCK_STABLE_CYCLES = 1024,
    parameter int unsigned MEAS_WINDOW        = 5000,
    parameter int unsigned EXP_COUNT          = 900,
    parameter int unsigned TOLERANCE          = 8,
    parameter int unsigned MAX_RETRIES        = 3,
    parameter int unsigned CNT_W              = 16
) (
    input  logic             refclk,
    input  logic             rst,
    input  logic             locked,
    input  logic             clk_tgl,
    output logic             pll_rst,
    output logic             domain_rst,
    output logic             ready,
    output logic             fault,
    output logic [1:0]       retry_cnt,
    output logic [7:0]       loss_cnt,
    output logic [CNT_W-1:0] last_count
);

    // One shared timer serves every state, so size it for the longest interval.
    localparam int unsigned TMR_MAX_A = (RST_PULSE_CYCLES > LOCK_TIMEOUT) ?
                                        RST_PULSE_CYCLES : LOCK_TIMEOUT;
    localparam int unsigned TMR_MAX_B = (LOCK_STABLE_CYCLES > MEAS_WINDOW) ?
                                        LOCK_STABLE_CYCLES : MEAS_WINDOW;
    localparam int unsigned TMR_MAX   = (TMR_MAX_A > TMR_MAX_B) ? TMR_MAX_A : TMR_MAX_B;
    localparam int unsigned TMR_W     = $clog2(TMR_MAX + 1);

    localparam logic [TMR_W-1:0] RstLast    = TMR_W'(RST_PULSE_CYCLES - 1);
    localparam logic [TMR_W-1:0] LockLast   = TMR_W'(LOCK_TIMEOUT - 1);
    localparam logic [TMR_W-1:0] StableLast = TMR_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [TMR_W-1:0] WinLast    = TMR_W'(MEAS_WINDOW - 1);
    localparam logic [CNT_W-1:0] CntMax     = {CNT_W{1'b1}};

    state_e             state_q, state_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_sat;
    logic [CNT_W-1:0]   last_q, last_d;
    logic [1:0]         retry_q, retry_d, retry_inc;
    logic [7:0]         loss_q, loss_d;
    logic               pll_rst_q, domain_rst_q, ready_q, fault_q;
    logic               locked_s, tgl_edge, unused_locked_edge;
    logic               win_end, win_ok;

    pll_sup_sync u_sync_locked (
        .clk_i  (refclk),
        .rst_i  (rst),
        .d_i    (locked),
        .q_o    (locked_s),
        .edge_o (unused_locked_edge)
    );

    logic unused_tgl_level;

    pll_sup_sync u_sync_tgl (
        .clk_i  (refclk),
        .rst_i  (rst),
        .d_i    (clk_tgl),
        .q_o    (unused_tgl_level),
        .edge_o (tgl_edge)
    );

    // Count including this cycle's edge, so an edge on the final window cycle is kept.
    assign cnt_sat   = (tgl_edge && (cnt_q != CntMax)) ? cnt_q + CNT_W'(1) : cnt_q;
    assign win_end   = (timer_q == WinLast);
    assign win_ok    = count_in_range(32'(cnt_sat), EXP_COUNT, TOLERANCE);
    assign retry_inc = retry_q + 2'd1;

    // Next-state, timer and counter logic
    always_comb begin
        state_d = state_q;
        timer_d = timer_q + TMR_W'(1);
        cnt_d   = cnt_q;
        last_d  = last_q;
        retry_d = retry_q;
        loss_d  = loss_q;
        unique case (state_q)
            StRstPll: begin
                if (timer_q == RstLast) begin
                    state_d = StWaitLock;
                    timer_d = '0;
                end
            end
            StWaitLock: begin
                if (locked_s) begin
                    state_d = StStable;
                    timer_d = '0;
                end else if (timer_q == LockLast) begin
                    state_d = StFail;
                    timer_d = '0;
                end
            end
            StStable: begin
                if (!locked_s) begin
                    state_d = StFail;
                    timer_d = '0;
                end else if (timer_q == StableLast) begin
                    state_d = StMeasure;
                    timer_d = '0;
                    cnt_d   = '0;
                end
            end
            StMeasure, StRun: begin
                cnt_d = cnt_sat;
                // Window close: publish the count and restart from zero next cycle.
                if (win_end) begin
                    last_d  = cnt_sat;
                    cnt_d   = '0;
                    timer_d = '0;
                end
                if (state_q == StMeasure) begin
                    if (!locked_s) begin
                        state_d = StFail;
                        timer_d = '0;
                    end else if (win_end) begin
                        if (win_ok) begin
                            state_d = StRun;
                            retry_d = 2'd0;
                        end else begin
                            state_d = StFail;
                        end
                    end
                end else if (!locked_s || (win_end && !win_ok)) begin
                    state_d = StRstPll;
                    timer_d = '0;
                    if (loss_q != 8'hFF) begin
                        loss_d = loss_q + 8'd1;
                    end
                end
            end
            StFail: begin
                timer_d = '0;
                retry_d = retry_inc;
                state_d = (32'(retry_inc) >= MAX_RETRIES) ? StFault : StRstPll;
            end
            StFault: begin
                timer_d = '0;
            end
            default: begin
                state_d = StRstPll;
                timer_d = '0;
            end
        endcase
    end

    // State, timer and status counter registers
    always_ff @(posedge refclk) begin
        if (rst) begin
            state_q <= StRstPll;
            timer_q <= '0;
            cnt_q   <= '0;
            last_q  <= '0;
            retry_q <= 2'd0;
            loss_q  <= 8'd0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            retry_q <= retry_d;
            loss_q  <= loss_d;
        end
    end

    // Registered control outputs decoded from the current state
    always_ff @(posedge refclk) begin
        if (rst) begin
            pll_rst_q    <= 1'b1;
            domain_rst_q <= 1'b1;
            ready_q      <= 1'b0;
            fault_q      <= 1'b0;
        end else begin
            pll_rst_q    <= (state_q == StRstPll);
            domain_rst_q <= (state_q != StRun);
            ready_q      <= (state_q == StRun);
            fault_q      <= (state_q == StFault);
        end
    end

    assign pll_rst    = pll_rst_q;
    assign domain_rst = domain_rst_q;
    assign ready      = ready_q;
    assign fault      = fault_q;
    assign retry_cnt  = retry_q;
    assign loss_cnt   = loss_q;
    assign last_count = last_q;

endmodule

// File: doc/pll_supervisor.md
Name: pll_supervisor

Overview:
- Sits in the refclk (50 MHz) domain, downstream of the audio PLL.
- Consumes the PLL's `locked` flag and a toggle derived from the PLL output clock, and drives the PLL's `rst`.
- Sequences PLL bring-up, verifies the output frequency by edge counting, and releases a reset for the audio-clock domain only while the PLL is locked and in tolerance.
- Retries on loss of lock or frequency error, and latches a sticky fault after repeated failures.

Parameters:
- RST_PULSE_CYCLES, 16, refclk cycles `pll_rst` is held high per attempt.
- LOCK_TIMEOUT, 50000, refclk cycles allowed for `locked` to rise.
- LOCK_STABLE_CYCLES, 1024, refclk cycles `locked` must stay high before measuring.
- MEAS_WINDOW, 5000, refclk cycles per frequency window (100 us).
- EXP_COUNT, 900, expected `clk_tgl` transitions per window (9 MHz output).
- TOLERANCE, 8, allowed ±deviation from EXP_COUNT, inclusive.
- MAX_RETRIES, 3, failed attempts before entering FAULT.
- CNT_W, 16, width of the measurement counter and `last_count`.

Ports:
- refclk, input, 1, 50 MHz reference clock; the only clock.
- rst, input, 1, synchronous active-high reset.
- locked, input, 1, PLL locked flag; asynchronous, synchronized internally.
- clk_tgl, input, 1, toggles on every outclk rising edge; asynchronous, synchronized internally.
- pll_rst, output, 1, drives the PLL rst input.
- domain_rst, output, 1, active-high reset for the audio-clock domain.
- ready, output, 1, high only in RUN.
- fault, output, 1, sticky; high in FAULT.
- retry_cnt, output, 2, failed attempts since the last successful RUN entry.
- loss_cnt, output, 8, saturating count of exits from RUN.
- last_count, output, CNT_W, transition count from the most recent completed window.

Behaviour:
- Reset values: `pll_rst`=1, `domain_rst`=1, `ready`=0, `fault`=0, `retry_cnt`=0, `loss_cnt`=0, `last_count`=0. State is RST_PLL, all timers are 0 and the synchronizers are cleared.
- Synchronization: `locked` and `clk_tgl` each pass through 2 flops. A transition is detected by XOR of the 2nd and 3rd flops of `clk_tgl`. All decisions use the synchronized values.
- All outputs are registered.
- `domain_rst` = NOT `ready`.
- `pll_rst` is high only in RST_PLL.

State machine:
- RST_PLL: hold for RST_PULSE_CYCLES cycles, then go to WAIT_LOCK.
- WAIT_LOCK:
  - `locked_s`=1 → STABLE, timer cleared.
  - Timer reaches LOCK_TIMEOUT → FAIL.
- STABLE:
  - `locked_s`=0 → FAIL.
  - Timer reaches LOCK_STABLE_CYCLES → MEASURE, window counter and edge counter cleared.
- MEASURE:
  - Count transitions for MEAS_WINDOW cycles.
  - At window end, `last_count` ← count.
  - Count within [EXP_COUNT−TOLERANCE, EXP_COUNT+TOLERANCE] → RUN and `retry_cnt` ← 0; otherwise → FAIL.
  - `locked_s`=0 at any cycle → FAIL.
- RUN:
  - `ready`=1.
  - Windows repeat back-to-back and `last_count` updates at each window end.
  - `locked_s`=0 or an out-of-range window → RST_PLL directly, `loss_cnt`+1 (saturates at 255), `retry_cnt` unchanged.
- FAIL (1 cycle):
  - `retry_cnt`+1.
  - If the new value ≥ MAX_RETRIES → FAULT; else → RST_PLL.
- FAULT: `fault`=1, `pll_rst`=0, `domain_rst`=1. Exit only via `rst`.

Boundary conditions:
- Latency: `locked` falling at the pin → `ready`/`domain_rst` change and `pll_rst` rises 4 refclk cycles later (2 sync + FSM + output register).
- Edge arriving on the window's final cycle: counted in that window.
- Counter reset at window start: takes priority over a same-cycle edge, so that edge counts as 1 in the new window.
- Edge counter saturates at 2^CNT_W−1; it never wraps.
- `locked` loss and window end in the same cycle: `locked` loss wins, but `last_count` still updates.
- `rst` mid-operation: immediate return to the reset values from any state, including FAULT.

Decomposition:
- Package pll_sup_pkg holds the state enum (RST_PLL, WAIT_LOCK, STABLE, MEASURE, RUN, FAIL, FAULT) and a function for the tolerance-range check.
- One sub-module, pll_sup_sync: a 3-flop synchronizer with edge output, instantiated for `locked` and for `clk_tgl`.

Test Plan:
All scenarios use sim parameters RST_PULSE_CYCLES=4, LOCK_TIMEOUT=100, LOCK_STABLE_CYCLES=8, MEAS_WINDOW=50, EXP_COUNT=18, TOLERANCE=1, MAX_RETRIES=3.
1. Nominal bring-up: `locked` rises 20 cycles after `pll_rst` falls; `clk_tgl` toggles every 2.78 refclk cycles → `pll_rst` high exactly 4 cycles, `ready`=1 after STABLE plus one window, `last_count` within 17–19, `retry_cnt`=0.
2. Frequency error: `clk_tgl` at 20 transitions/window → FAIL; three attempts → `fault`=1, `pll_rst`=0, `domain_rst`=1, `retry_cnt`=3.
3. Lock timeout: `locked` held 0 → `pll_rst` re-pulses every 4+100+1 cycles; FAULT after the 3rd timeout.
4. Loss in RUN: drop `locked` for 1 cycle → `ready` low 4 cycles later, `loss_cnt`=1, PLL re-reset, RUN re-entered after recovery.
5. Boundary counts: windows with 17 and 19 transitions → stay in RUN; 16 → exit RUN; transition placed on the last window cycle → included in `last_count`.
6. `rst` asserted during MEASURE and during FAULT → all outputs return to their reset values on the next edge; then a nominal re-sequence.
